// File: rtl/ifetch_queue.sv
// Byte-serial instruction fetcher: assembles 32-bit little-endian words from a
// byte-wide bus and queues them with their PCs; redirect flushes in one cycle.
module ifetch_queue #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    IQ_DEPTH   = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic [7:0]                mem_din,
   output logic [31:0]               mem_a,
   output logic                      mem_wr,
   output logic                      bus_req,
   input  logic                      bus_gnt,
   input  logic                      redirect_valid,
   input  logic [ADDR_WIDTH-1:0]     redirect_pc,
   output logic                      inst_valid,
   output logic [31:0]               inst_out,
   output logic [ADDR_WIDTH-1:0]     inst_pc,
   input  logic                      inst_ready,
   output logic [$clog2(IQ_DEPTH):0] iq_count
);

   localparam int                    PW      = $clog2(IQ_DEPTH);
   localparam logic [PW+1:0]         DEPTH_W = IQ_DEPTH[PW+1:0];
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   typedef struct packed {
      logic [31:0]           inst;
      logic [ADDR_WIDTH-1:0] pc;
   } iq_entry_t;

   state_t                state_q, state_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [31:0]           asm_q, asm_d, asm_m;
   logic                  cap_vld_q, cap_vld_d;
   logic [1:0]            cap_lane_q, cap_lane_d;
   logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
   logic [PW:0]           count_q, count_d;
   iq_entry_t             iq_q [IQ_DEPTH];

   logic                  inflight, start_ok, req, issue, redir, push, pop;
   logic [PW+1:0]         occ;
   logic [1:0]            lane;
   logic [ADDR_WIDTH-1:0] addr;

   // Request / address generation; a new instruction needs a free queue slot
   // reserved for it, counting the one currently being assembled.
   always_comb begin
      inflight = (state_q != S_IDLE);
      occ      = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight};
      start_ok = (occ < DEPTH_W);
      lane     = 2'd0;
      addr     = fetch_pc_q;
      req      = 1'b0;
      case (state_q)
         S_ISSUE: begin
            req  = 1'b1;
            lane = byte_idx_q;
            addr = fetch_pc_q + {{(ADDR_WIDTH-2){1'b0}}, byte_idx_q};
         end
         S_DRAIN: begin
            req  = start_ok;
            addr = fetch_pc_q + PC_STEP;
         end
         default: req = start_ok;
      endcase
      if (rst_in || redirect_valid) req = 1'b0;
   end

   assign bus_req = req;
   assign issue   = req & bus_gnt & rdy_in;
   assign mem_a   = req ? 32'(addr) : 32'd0;
   assign mem_wr  = 1'b0;

   assign redir = rdy_in & redirect_valid;
   assign push  = rdy_in & ~redirect_valid & (state_q == S_DRAIN);
   assign pop   = rdy_in & ~redirect_valid & inst_valid & inst_ready;

   // Byte returned this cycle merged into the assembly word; a push in DRAIN
   // may take lane 3 straight from the bus.
   always_comb begin
      asm_m = asm_q;
      if (cap_vld_q) asm_m[{cap_lane_q, 3'b000} +: 8] = mem_din;
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      fetch_pc_d = fetch_pc_q;
      asm_d      = redir ? asm_q : asm_m;
      cap_vld_d  = issue;
      cap_lane_d = lane;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      if (redir) begin
         state_d    = S_IDLE;
         byte_idx_d = 2'd0;
         fetch_pc_d = redirect_pc;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else if (rdy_in) begin
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  state_d    = S_ISSUE;
                  byte_idx_d = issue ? 2'd1 : 2'd0;
               end
            end
            S_ISSUE: begin
               if (issue) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) state_d = S_DRAIN;
               end
            end
            default: begin
               fetch_pc_d = fetch_pc_q + PC_STEP;
               state_d    = issue ? S_ISSUE : S_IDLE;
               byte_idx_d = issue ? 2'd1 : 2'd0;
            end
         endcase
         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         byte_idx_q <= 2'd0;
         fetch_pc_q <= RESET_PC;
         asm_q      <= '0;
         cap_vld_q  <= 1'b0;
         cap_lane_q <= 2'd0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         for (int i = 0; i < IQ_DEPTH; i++) iq_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         fetch_pc_q <= fetch_pc_d;
         asm_q      <= asm_d;
         cap_vld_q  <= cap_vld_d;
         cap_lane_q <= cap_lane_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         if (push) iq_q[tail_q] <= '{inst: asm_m, pc: fetch_pc_q};
      end
   end

   assign inst_valid = (count_q != '0);
   assign inst_out   = iq_q[head_q].inst;
   assign inst_pc    = iq_q[head_q].pc;
   assign iq_count   = count_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (IQ_DEPTH=4) with a byte-wide memory model.
module tb_ifetch_queue;

   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in, bus_gnt, redirect_valid, inst_ready;
   logic [7:0]    mem_din;
   logic [31:0]   mem_a, inst_out;
   logic          mem_wr, bus_req, inst_valid;
   logic [AW-1:0] redirect_pc, inst_pc;
   logic [2:0]    iq_count;

   logic [7:0]    mem [1024];
   int            total = 0;
   int            bad   = 0;
   wire           issue_w = bus_req & bus_gnt & rdy_in;

   ifetch_queue #(.ADDR_WIDTH(AW), .IQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
      .mem_a(mem_a), .mem_wr(mem_wr), .bus_req(bus_req), .bus_gnt(bus_gnt),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .iq_count(iq_count)
   );

   always #5 clk_in = ~clk_in;

   // Memory answers one cycle after an issue; otherwise drives a poison byte.
   always @(posedge clk_in)
      if (bus_req && bus_gnt && rdy_in) mem_din <= mem[mem_a[9:0]];
      else                              mem_din <= 8'hEE;

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      logic [9:0] a;
      a = pc[9:0];
      return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
   endfunction

   task automatic step();
      @(negedge clk_in);
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; rdy_in = 1'b1; bus_gnt = 1'b1; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) begin step(); #1; end
      if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%0h exp=0", bus_req); end
      total++;
      if (inst_valid !== 1'b0 || iq_count !== 3'd0) begin bad++; $display("FAIL rst_queue valid=%0h cnt=%0d exp 0/0", inst_valid, iq_count); end
      total++;
      if (inst_out !== 32'h0 || inst_pc !== 32'h0 || mem_a !== 32'h0 || mem_wr !== 1'b0) begin
         bad++; $display("FAIL rst_outs out=%h pc=%h a=%h wr=%0h exp all 0", inst_out, inst_pc, mem_a, mem_wr);
      end
      total++;
      step(); rst_in = 1'b0; #1;
      if (bus_req !== 1'b1 || mem_a !== 32'h0) begin bad++; $display("FAIL first_issue req=%0h a=%h exp 1/0", bus_req, mem_a); end
      total++;
      for (int k = 1; k < 4; k++) begin
         step(); #1;
         if (bus_req !== 1'b1 || mem_a !== 32'(k)) begin bad++; $display("FAIL issue_byte%0d a=%h exp=%h", k, mem_a, 32'(k)); end
         total++;
      end
      step(); #1;
      if (inst_valid !== 1'b0 || mem_a !== 32'h4) begin bad++; $display("FAIL cycle5 valid=%0h a=%h exp 0/4", inst_valid, mem_a); end
      total++;
      step(); #1;
      if (inst_valid !== 1'b1 || inst_out !== 32'h00100513 || inst_pc !== 32'h0 || iq_count !== 3'd1) begin
         bad++; $display("FAIL first_inst valid=%0h out=%h pc=%h cnt=%0d exp 1/00100513/0/1", inst_valid, inst_out, inst_pc, iq_count);
      end
      total++;
   endtask

   task automatic test_fill();
      int n;
      for (int c = 0; c < 40 && iq_count != 3'd4; c++) begin step(); #1; end
      if (iq_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", iq_count); end
      total++;
      repeat (6) begin
         step(); #1;
         if (bus_req !== 1'b0) begin bad++; $display("FAIL full_no_req got=%0h exp=0", bus_req); end
         total++;
      end
      step(); inst_ready = 1'b1; #1;
      if (inst_pc !== 32'h0 || inst_out !== word_at(32'h0)) begin bad++; $display("FAIL fill_head pc=%h out=%h exp 0/%h", inst_pc, inst_out, word_at(32'h0)); end
      total++;
      step(); inst_ready = 1'b0; #1;
      if (iq_count !== 3'd3 || bus_req !== 1'b1 || mem_a !== 32'h10) begin
         bad++; $display("FAIL refetch cnt=%0d req=%0h a=%h exp 3/1/10", iq_count, bus_req, mem_a);
      end
      total++;
      n = issue_w ? 1 : 0;
      repeat (20) begin step(); #1; n += issue_w ? 1 : 0; end
      if (n !== 4) begin bad++; $display("FAIL refetch_issues got=%0d exp=4", n); end
      total++;
      if (iq_count !== 3'd4 || inst_pc !== 32'h4 || inst_out !== word_at(32'h4)) begin
         bad++; $display("FAIL refill cnt=%0d pc=%h out=%h exp 4/4/%h", iq_count, inst_pc, inst_out, word_at(32'h4));
      end
      total++;
   endtask

   task automatic test_redirect();
      logic found;
      inst_ready = 1'b0; bus_gnt = 1'b1;
      step(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      if (bus_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%0h exp=0", bus_req); end
      total++;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         step(); #1;
         if (issue_w && mem_a == 32'h4A) found = 1'b1;
      end
      if (found !== 1'b1) begin bad++; $display("FAIL redir_seek got=%0h exp=1", found); end
      total++;
      step(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      if (iq_count !== 3'd2 || bus_req !== 1'b0) begin bad++; $display("FAIL redir_pre cnt=%0d req=%0h exp 2/0", iq_count, bus_req); end
      total++;
      step(); #1;
      if (inst_valid !== 1'b0 || iq_count !== 3'd0) begin bad++; $display("FAIL redir_flush valid=%0h cnt=%0d exp 0/0", inst_valid, iq_count); end
      total++;
      if (bus_req !== 1'b1 || mem_a !== 32'h100) begin bad++; $display("FAIL redir_addr req=%0h a=%h exp 1/100", bus_req, mem_a); end
      total++;
      for (int c = 0; c < 20 && !inst_valid; c++) begin step(); #1; end
      if (inst_pc !== 32'h100 || inst_out !== word_at(32'h100)) begin
         bad++; $display("FAIL redir_word pc=%h out=%h exp 100/%h", inst_pc, inst_out, word_at(32'h100));
      end
      total++;
   endtask

   task automatic test_push_pop();
      logic [31:0] exp_pc;
      logic        push_next, was_pp;
      int          npp;
      step(); inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
      exp_pc = 32'h300; npp = 0; push_next = 1'b0; was_pp = 1'b0;
      for (int c = 0; c < 150 && npp < 3 * DEPTH; c++) begin
         step();
         inst_ready = push_next && (iq_count == 3'd1);
         #1;
         if (was_pp) begin
            if (iq_count !== 3'd1) begin bad++; $display("FAIL pp_count got=%0d exp=1", iq_count); end
            total++;
         end
         was_pp = inst_ready;
         if (inst_ready) begin
            if (inst_pc !== exp_pc || inst_out !== word_at(exp_pc)) begin
               bad++; $display("FAIL pp_head pc=%h out=%h exp %h/%h", inst_pc, inst_out, exp_pc, word_at(exp_pc));
            end
            total++;
            exp_pc = exp_pc + 32'd4;
            npp++;
         end
         push_next = issue_w && (mem_a[1:0] == 2'd3);
      end
      step(); inst_ready = 1'b0; #1;
      if (npp !== 3 * DEPTH || iq_count !== 3'd1) begin bad++; $display("FAIL pp_total pops=%0d cnt=%0d exp %0d/1", npp, iq_count, 3 * DEPTH); end
      total++;
      if (inst_pc !== exp_pc || inst_out !== word_at(exp_pc)) begin
         bad++; $display("FAIL pp_wrap pc=%h out=%h exp %h/%h", inst_pc, inst_out, exp_pc, word_at(exp_pc));
      end
      total++;
   endtask

   task automatic test_grant_loss();
      logic found;
      step(); inst_ready = 1'b0; bus_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         step(); #1;
         if (issue_w && mem_a == 32'h201) found = 1'b1;
      end
      repeat (3) begin
         step(); bus_gnt = 1'b0; #1;
         if (bus_req !== 1'b1 || mem_a !== 32'h202) begin bad++; $display("FAIL gnt_hold req=%0h a=%h exp 1/202", bus_req, mem_a); end
         total++;
      end
      step(); bus_gnt = 1'b1; #1;
      if (issue_w !== 1'b1 || mem_a !== 32'h202) begin bad++; $display("FAIL gnt_resume iss=%0h a=%h exp 1/202", issue_w, mem_a); end
      total++;
      for (int c = 0; c < 20 && !inst_valid; c++) begin step(); #1; end
      if (inst_pc !== 32'h200 || inst_out !== word_at(32'h200)) begin
         bad++; $display("FAIL gnt_word pc=%h out=%h exp 200/%h", inst_pc, inst_out, word_at(32'h200));
      end
      total++;
   endtask

   task automatic test_rdy_stall();
      logic found;
      step(); inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h280; #1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         step(); #1;
         if (issue_w && mem_a == 32'h285) found = 1'b1;
      end
      repeat (5) begin
         step(); rdy_in = 1'b0; inst_ready = 1'b1; #1;
         if (issue_w !== 1'b0 || iq_count !== 3'd1 || inst_valid !== 1'b1 || inst_pc !== 32'h280) begin
            bad++; $display("FAIL stall_hold iss=%0h cnt=%0d valid=%0h pc=%h exp 0/1/1/280", issue_w, iq_count, inst_valid, inst_pc);
         end
         total++;
      end
      step(); rdy_in = 1'b1; inst_ready = 1'b0; #1;
      if (bus_req !== 1'b1 || mem_a !== 32'h286) begin bad++; $display("FAIL stall_resume req=%0h a=%h exp 1/286", bus_req, mem_a); end
      total++;
      for (int c = 0; c < 20 && iq_count != 3'd2; c++) begin step(); #1; end
      step(); inst_ready = 1'b1; #1;
      if (inst_pc !== 32'h280 || inst_out !== word_at(32'h280)) begin
         bad++; $display("FAIL stall_head0 pc=%h out=%h exp 280/%h", inst_pc, inst_out, word_at(32'h280));
      end
      total++;
      step(); inst_ready = 1'b0; #1;
      if (inst_pc !== 32'h284 || inst_out !== word_at(32'h284)) begin
         bad++; $display("FAIL stall_head1 pc=%h out=%h exp 284/%h", inst_pc, inst_out, word_at(32'h284));
      end
      total++;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
      mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
      test_reset();
      test_fill();
      test_redirect();
      test_push_pop();
      test_grant_loss();
      test_rdy_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch unit between the byte-wide unified memory bus and the decode/dispatch stage. Fetches sequential 32-bit little-endian instructions one byte per bus cycle under an external bus grant. Buffers them with their PCs in an IQ_DEPTH-entry FIFO. Supports single-cycle redirect/flush from branch resolution.

## Interface
- ADDR_WIDTH, 32, width of PC and of redirect/instruction PC ports.
- IQ_DEPTH, 8, instruction queue entries; power of two, at least 2.
- RESET_PC, 0, fetch start address after reset.

- clk_in  input  1  clock; all state changes on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  global enable; 0 freezes all state except in-flight byte capture.
- mem_din  input  8  read data; byte for the address issued in cycle t is valid in cycle t+1.
- mem_a  output  32  byte address; meaningful only in issue cycles.
- mem_wr  output  1  constant 0 (read only).
- bus_req  output  1  fetcher wants to issue a byte this cycle; combinational from state, independent of bus_gnt.
- bus_gnt  input  1  arbiter grant, combinational response to bus_req.
- redirect_valid  input  1  flush and restart at redirect_pc.
- redirect_pc  input  ADDR_WIDTH  new fetch PC, 4-byte aligned.
- inst_valid  output  1  queue non-empty.
- inst_out  output  32  instruction at queue head.
- inst_pc  output  ADDR_WIDTH  PC of head instruction.
- inst_ready  input  1  consumer pops head when inst_valid and inst_ready.
- iq_count  output  $clog2(IQ_DEPTH)+1  occupied entries.

## Operation
- Issue condition: issue = bus_req & bus_gnt & rdy_in. In an issue cycle, mem_a = fetch_pc + byte_idx (zero-extended/truncated to 32), mem_wr = 0.
- bus_req = 1 when an instruction is in assembly with byte_idx ≤ 3 and bytes remain to issue. It is also 1 when a new instruction may start, i.e. (iq_count + inflight) < IQ_DEPTH. inflight is 1 while an instruction is being assembled.
- FSM states:
  - IDLE: no instruction in assembly.
  - ISSUE: byte_idx 0..3 being issued.
  - DRAIN: all 4 addresses issued, last byte pending.
- Transitions:
  - IDLE→ISSUE when the start condition holds. Byte 0 issues in that same cycle if granted.
  - ISSUE advances byte_idx on each issue. Issuing byte 3 moves to DRAIN.
  - DRAIN returns to IDLE, or to ISSUE with the next PC if the start condition holds and is granted. Back-to-back fetch is allowed: the byte 0 issue of the next instruction overlaps the byte 3 capture of the current one.
- Capture: the byte issued in cycle t is written into lane byte_idx[t] of the assembly register at the end of cycle t+1. Capture happens even if rdy_in=0 in cycle t+1. Lane k maps to bits [8k+7:8k].
- Push: at the edge capturing byte 3, {instruction, fetch_pc} is written at tail. Then fetch_pc += 4, tail wraps modulo IQ_DEPTH, and inflight clears.
- Grant loss mid-instruction: byte_idx holds. Already-issued bytes are still captured. Issuing resumes when grant returns.
- Pop: head advances modulo IQ_DEPTH. Simultaneous push and pop leaves iq_count unchanged. Overflow is impossible by the reservation rule; underflow is prevented by gating the pop with inst_valid.
- Redirect (rdy_in=1) takes priority over push and pop:
  - queue emptied, head = tail = 0, iq_count = 0;
  - assembly aborted; any byte arriving next cycle is discarded;
  - fetch_pc = redirect_pc; FSM = IDLE.
  - bus_req is 0 in the redirect cycle. Fetch restarts the following cycle.
- rst_in has priority over redirect_valid and rdy_in.

## Timing
- Reset values: fetch_pc = RESET_PC, FSM IDLE, iq_count 0, inst_valid 0, inst_out 0, inst_pc 0, bus_req 0, mem_a 0, mem_wr 0. Pending byte capture is discarded.
- First cycle after rst_in deasserts: bus_req = 1, mem_a = RESET_PC if granted.
- Latency with continuous grant: first byte issued in cycle t0 gives inst_valid = 1 in cycle t0+5.
- Steady-state throughput is one instruction per 4 cycles.
- inst_out, inst_pc and inst_valid are read directly from queue state with no extra register stage. A push into an empty queue is visible the next cycle.
- Redirect asserted in cycle r: inst_valid = 0 in cycle r+1; first redirected byte issued no earlier than r+1.

## Test plan
- Reset, RESET_PC=0, memory bytes 0x13,0x05,0x10,0x00 at 0..3, grant always 1, inst_ready 0 -> mem_a 0,1,2,3 in cycles 1-4; inst_valid in cycle 6 with inst_out 0x00100513, inst_pc 0.
- Queue fill with IQ_DEPTH=4, inst_ready 0 -> iq_count reaches 4, bus_req stays 0; then one pop -> exactly one more fetch, PC 0x10.
- bus_gnt low for 3 cycles after byte 1 issued -> byte 1 still captured, byte 2 address issued on first regranted cycle, assembled word correct.
- redirect_valid with redirect_pc 0x100 while byte 2 in flight and 2 entries queued -> next cycle inst_valid 0, iq_count 0; next issued address 0x100; stale byte never appears.
- Push and pop in the same cycle with iq_count 1 -> iq_count stays 1; head PC advances by 4; pointer wrap at IQ_DEPTH verified over 3·IQ_DEPTH instructions.
- rdy_in 0 for 5 cycles mid-instruction -> no issue, no push/pop, outputs stable; in-flight byte captured; fetch resumes with correct word after rdy_in returns.
